// File: rtl/ofifo_pkg.sv
// Shared defaults and helpers for the output FIFO (ofifo) and its per-column lanes.
package ofifo_pkg;

  localparam int unsigned COL_DEF     = 8;
  localparam int unsigned PSUM_BW_DEF = 16;
  localparam int unsigned DEPTH_DEF   = 16;

  // Pointer width: one extra MSB tells full from empty once the pointers wrap.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_lane.sv
// Single psum_bw-wide circular FIFO lane with first-word-fall-through output.
module fifo_lane
  import ofifo_pkg::*;
#(
  parameter int unsigned psum_bw = PSUM_BW_DEF,
  parameter int unsigned depth   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] din,
  input  logic               rd,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam int unsigned PW = ptr_w(depth);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [psum_bw-1:0] mem_q [depth];
  logic               do_wr;
  logic               do_rd;

  // Status decodes come from the current pointers only.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    dout  = mem_q[rptr_q[AW-1:0]];
  end

  // A write into a full lane is dropped even when a pop happens on the same edge.
  always_comb begin
    do_wr  = wr & ~full;
    do_rd  = rd & ~empty;
    wptr_d = wptr_q + PW'(do_wr);
    rptr_d = rptr_q + PW'(do_rd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ofifo.sv
// Output FIFO: one fifo_lane per array column, popped in lockstep once every lane has data.
// Optional sticky misuse flag o_err is built when OFIFO_ERR_EN is defined.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int unsigned col     = COL_DEF,
  parameter int unsigned psum_bw = PSUM_BW_DEF,
  parameter int unsigned depth   = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready
`ifdef OFIFO_ERR_EN
  ,
  output logic                   o_err
`endif
);

  logic [col-1:0] lane_empty;
  logic [col-1:0] lane_full;
  logic           rd_gated;

  // Lanes fill skewed, so output is valid only when the last lane has an entry.
  always_comb begin
    o_valid  = ~(|lane_empty);
    o_full   = |lane_full;
    o_ready  = ~o_full;
    rd_gated = rd & o_valid;
  end

  for (genvar i = 0; i < int'(col); i++) begin : g_lane
    fifo_lane #(
      .psum_bw(psum_bw),
      .depth  (depth)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .wr   (wr[i]),
      .din  (in[psum_bw*i +: psum_bw]),
      .rd   (rd_gated),
      .dout (out[psum_bw*i +: psum_bw]),
      .empty(lane_empty[i]),
      .full (lane_full[i])
    );
  end

`ifdef OFIFO_ERR_EN
  logic err_q, err_d;

  // Sticky on any dropped write or any pop request while not valid.
  always_comb begin
    err_d = err_q;
    if ((|(wr & lane_full)) || (rd && !o_valid)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`endif

endmodule

// File: tb/tb_ofifo.sv
// Self-checking bench for ofifo against a queue-based lane model; checks o_err when OFIFO_ERR_EN is defined.
module tb_ofifo;

  localparam int unsigned COL   = 8;
  localparam int unsigned BW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned W     = COL * BW;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   din;
  logic [W-1:0]   dout;
  logic [COL-1:0] wr;
  logic           rd;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;
`ifdef OFIFO_ERR_EN
  logic           o_err;
  logic           m_err;
`endif

  int errors = 0;
  int checks = 0;

  logic [BW-1:0] mq [COL][$];

  always #5 clk = ~clk;

  ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .in     (din),
    .wr     (wr),
    .rd     (rd),
    .out    (dout),
    .o_valid(o_valid),
    .o_full (o_full),
    .o_ready(o_ready)
`ifdef OFIFO_ERR_EN
    ,
    .o_err  (o_err)
`endif
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_valid();
    for (int i = 0; i < int'(COL); i++) if (mq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < int'(COL); i++) if (mq[i].size() == int'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] rand_bus();
    logic [W-1:0] v;
    for (int i = 0; i < int'(COL); i++) v[i*BW +: BW] = BW'($urandom);
    return v;
  endfunction

  task automatic check_outs(input string tag);
    logic [W-1:0] exp;
    check({tag, ".valid"}, W'(o_valid), W'(m_valid()));
    check({tag, ".full"},  W'(o_full),  W'(m_full()));
    check({tag, ".ready"}, W'(o_ready), W'(!m_full()));
`ifdef OFIFO_ERR_EN
    check({tag, ".err"},   W'(o_err),   W'(m_err));
`endif
    if (m_valid()) begin
      for (int i = 0; i < int'(COL); i++) exp[i*BW +: BW] = mq[i][0];
      check({tag, ".out"}, dout, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, update the model, compare.
  task automatic step(input logic [COL-1:0] w, input logic r, input logic [W-1:0] d, input string tag);
    logic [COL-1:0] push;
    logic           pop;
    wr  = w;
    rd  = r;
    din = d;
    pop = r && m_valid();
    for (int i = 0; i < int'(COL); i++) push[i] = w[i] && (mq[i].size() < int'(DEPTH));
`ifdef OFIFO_ERR_EN
    if ((w & ~push) != '0 || (r && !m_valid())) m_err = 1'b1;
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(COL); i++) begin
      if (pop) void'(mq[i].pop_front());
      if (push[i]) mq[i].push_back(d[i*BW +: BW]);
    end
    wr = '0;
    rd = 1'b0;
    check_outs(tag);
  endtask

  // Reset pulse with wr/rd held high; its effect must be immediate and the strobes ignored.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    wr    = '1;
    rd    = 1'b1;
    din   = rand_bus();
    #2;
    check({tag, ".imm_valid"}, W'(o_valid), W'(0));
    check({tag, ".imm_full"},  W'(o_full),  W'(0));
    check({tag, ".imm_ready"}, W'(o_ready), W'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr    = '0;
    rd    = 1'b0;
    for (int i = 0; i < int'(COL); i++) mq[i].delete();
`ifdef OFIFO_ERR_EN
    m_err = 1'b0;
`endif
    check_outs(tag);
  endtask

  initial begin
    logic [W-1:0] exp_skew;
    reset = 1'b1;
    wr    = '0;
    rd    = 1'b0;
    din   = '0;
`ifdef OFIFO_ERR_EN
    m_err = 1'b0;
`endif
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst.valid", W'(o_valid), W'(0));
    check("rst.full",  W'(o_full),  W'(0));
    check("rst.ready", W'(o_ready), W'(1));
    repeat (3) step('0, 1'b1, rand_bus(), "rst.rd_ignored");
    check("rst.valid_after_rd", W'(o_valid), W'(0));

    // Skewed fill: lane i receives 0x0100+i on cycle i.
    do_reset("skew.rst");
    for (int i = 0; i < int'(COL); i++) begin
      step(COL'(1) << i, 1'b0, {COL{BW'(16'h0100 + i)}}, "skew.fill");
      if (i < int'(COL) - 1) check("skew.valid_low", W'(o_valid), W'(0));
    end
    for (int i = 0; i < int'(COL); i++) exp_skew[i*BW +: BW] = BW'(16'h0100 + i);
    check("skew.valid_high", W'(o_valid), W'(1));
    check("skew.out", dout, exp_skew);
    step('0, 1'b1, '0, "skew.pop");
    check("skew.valid_after_pop", W'(o_valid), W'(0));

    // Full and drop: 16 writes fill every lane; a 17th write with a pop is dropped.
    do_reset("full.rst");
    repeat (DEPTH) step('1, 1'b0, rand_bus(), "full.fill");
    check("full.full",  W'(o_full),  W'(1));
    check("full.ready", W'(o_ready), W'(0));
    step('1, 1'b1, rand_bus(), "full.drop");
    check("full.not_full", W'(o_full), W'(0));
`ifdef OFIFO_ERR_EN
    check("full.err_set", W'(o_err), W'(1));
`endif
    repeat (DEPTH - 1) step('0, 1'b1, '0, "full.drain");
    check("full.empty_after_15", W'(o_valid), W'(0));

    // Wrap-around: 40 words streamed with simultaneous wr/rd.
    do_reset("wrap.rst");
    step('1, 1'b0, rand_bus(), "wrap.first");
    repeat (39) step('1, 1'b1, rand_bus(), "wrap.stream");
    step('0, 1'b1, '0, "wrap.last");
    check("wrap.empty", W'(o_valid), W'(0));

    // Random mixed traffic, including skewed masks and drops.
    do_reset("rand.rst");
    repeat (400) step(COL'($urandom), 1'($urandom_range(0, 1)), rand_bus(), "rand");

    // Mid-operation reset between edges discards queued data.
    do_reset("mid.rst0");
    repeat (5) step('1, 1'b0, rand_bus(), "mid.fill");
    check("mid.valid_before", W'(o_valid), W'(1));
    reset = 1'b1;
    #2;
    check("mid.valid_imm", W'(o_valid), W'(0));
    check("mid.ready_imm", W'(o_ready), W'(1));
    reset = 1'b0;
    for (int i = 0; i < int'(COL); i++) mq[i].delete();
`ifdef OFIFO_ERR_EN
    m_err = 1'b0;
`endif
    step('1, 1'b0, {COL{16'hBEEF}}, "mid.beef");
    check("mid.beef_out", dout, {COL{16'hBEEF}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
